// File: rtl/lcd2002_bus_receiver.sv
// lcd2002_bus_receiver: HD44780-style bus receiver holding a 20x2 DDRAM image.
// Define LCD_RX_BLANK_WHEN_OFF_EN to blank the row buses while the display is off.
module lcd2002_bus_receiver #(
  parameter int unsigned BUSY_CYCLES       = 2000,
  parameter int unsigned CLEAR_BUSY_CYCLES = 82000
) (
  input  logic         CLK,
  input  logic         _RST,
  input  logic         LCD_E,
  input  logic         LCD_RS,
  input  logic         rw,
  input  logic [7:0]   LCD_DATA,
  output logic [159:0] row_1,
  output logic [159:0] row_2,
  output logic         disp_on,
  output logic         two_line,
  output logic [6:0]   addr,
  output logic         busy,
  output logic         cmd_strobe,
  output logic         data_strobe,
  output logic         overrun
);

  localparam logic [16:0] BusyLd  = 17'(BUSY_CYCLES);
  localparam logic [16:0] ClearLd = 17'(CLEAR_BUSY_CYCLES);
  localparam logic [7:0]  Blank   = 8'h20;

  logic [2:0]   e_q;
  logic [1:0]   rs_q, rw_q;
  logic [7:0]   dat1_q, dat2_q;
  logic [7:0]   ram_q [40];
  logic [7:0]   ram_d [40];
  logic [16:0]  cnt_q, cnt_d;
  logic [6:0]   addr_q, addr_d;
  logic         disp_q, disp_d;
  logic         two_q, two_d;
  logic         id_q, id_d;
  logic         cg_q, cg_d;
  logic         cmd_q, cmd_d;
  logic         dstb_q, dstb_d;
  logic         ovr_q, ovr_d;
  logic         fall, exec;
  logic [5:0]   idx;
  logic [7:0]   d;
  logic [159:0] row1_w, row2_w;

  function automatic logic [6:0] step(input logic [6:0] a,
                                      input logic inc);
    logic [6:0] r;
    if (inc)
      r = (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : a + 7'd1;
    else
      r = (a == 7'h00) ? 7'h67 : (a == 7'h40) ? 7'h27 : a - 7'd1;
    return r;
  endfunction

  function automatic logic [6:0] amap(input logic [6:0] v);
    logic [6:0] r;
    r = v;
    if (v >= 7'h68)
      r = 7'h00;
    else if (v >= 7'h28 && v <= 7'h3f)
      r = 7'h40;
    return r;
  endfunction

  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      e_q    <= '0;
      rs_q   <= '0;
      rw_q   <= '0;
      dat1_q <= '0;
      dat2_q <= '0;
    end else begin
      e_q    <= {e_q[1:0], LCD_E};
      rs_q   <= {rs_q[0], LCD_RS};
      rw_q   <= {rw_q[0], rw};
      dat1_q <= LCD_DATA;
      dat2_q <= dat1_q;
    end
  end

  assign fall = e_q[2] & ~e_q[1];
  assign exec = fall & ~rw_q[1];
  assign d    = dat2_q;
  // both visible windows use offsets 0..19 within their 0x40 half
  assign idx  = addr_q[6] ? addr_q[5:0] + 6'd20 : addr_q[5:0];

  always_comb begin
    ram_d  = ram_q;
    cnt_d  = (cnt_q != '0) ? cnt_q - 17'd1 : cnt_q;
    addr_d = addr_q;
    disp_d = disp_q;
    two_d  = two_q;
    id_d   = id_q;
    cg_d   = cg_q;
    cmd_d  = 1'b0;
    dstb_d = 1'b0;
    ovr_d  = ovr_q;
    if (exec) begin
      ovr_d = ovr_q | (cnt_q != '0);
      cnt_d = BusyLd;
      if (rs_q[1]) begin
        dstb_d = 1'b1;
        if (!cg_q) begin
          if (addr_q[5:0] < 6'd20)
            ram_d[idx] = d;
          addr_d = step(addr_q, id_q);
        end
      end else begin
        cmd_d = 1'b1;
        priority case (1'b1)
          d[7]: begin
            addr_d = amap(d[6:0]);
            cg_d   = 1'b0;
          end
          d[6]: cg_d = 1'b1;
          d[5]: two_d = d[3];
          d[4]: if (!d[3]) addr_d = step(addr_q, d[2]);
          d[3]: disp_d = d[2];
          d[2]: id_d = d[1];
          d[1]: addr_d = '0;
          d[0]: begin
            for (int i = 0; i < 40; i++)
              ram_d[i] = Blank;
            addr_d = '0;
            id_d   = 1'b1;
            cnt_d  = ClearLd;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      for (int i = 0; i < 40; i++)
        ram_q[i] <= Blank;
      cnt_q  <= '0;
      addr_q <= '0;
      disp_q <= 1'b0;
      two_q  <= 1'b0;
      id_q   <= 1'b1;
      cg_q   <= 1'b0;
      cmd_q  <= 1'b0;
      dstb_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      for (int i = 0; i < 40; i++)
        ram_q[i] <= ram_d[i];
      cnt_q  <= cnt_d;
      addr_q <= addr_d;
      disp_q <= disp_d;
      two_q  <= two_d;
      id_q   <= id_d;
      cg_q   <= cg_d;
      cmd_q  <= cmd_d;
      dstb_q <= dstb_d;
      ovr_q  <= ovr_d;
    end
  end

  always_comb begin
    row1_w = '0;
    row2_w = '0;
    for (int i = 0; i < 20; i++) begin
      row1_w[159-8*i -: 8] = ram_q[i];
      row2_w[159-8*i -: 8] = ram_q[i+20];
    end
  end

`ifdef LCD_RX_BLANK_WHEN_OFF_EN
  assign row_1 = disp_q ? row1_w : {20{Blank}};
  assign row_2 = disp_q ? row2_w : {20{Blank}};
`else
  assign row_1 = row1_w;
  assign row_2 = row2_w;
`endif

  assign disp_on     = disp_q;
  assign two_line    = two_q;
  assign addr        = addr_q;
  assign busy        = (cnt_q != '0);
  assign cmd_strobe  = cmd_q;
  assign data_strobe = dstb_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_lcd2002_bus_receiver.sv
// tb_lcd2002_bus_receiver: vector table plus strobe scoreboard
// for the LCD2002 bus receiver.
module tb_lcd2002_bus_receiver;

  localparam int BUSY = 2000;
  localparam int CLR  = 5000;

  logic         CLK = 1'b0;
  logic         _RST = 1'b0;
  logic         LCD_E = 1'b0;
  logic         LCD_RS = 1'b0;
  logic         rw = 1'b0;
  logic [7:0]   LCD_DATA = 8'h00;
  logic [159:0] row_1, row_2;
  logic         disp_on, two_line, busy;
  logic         cmd_strobe, data_strobe, overrun;
  logic [6:0]   addr;

  lcd2002_bus_receiver #(
    .BUSY_CYCLES(BUSY),
    .CLEAR_BUSY_CYCLES(CLR)
  ) dut (
    .CLK(CLK), ._RST(_RST), .LCD_E(LCD_E), .LCD_RS(LCD_RS),
    .rw(rw), .LCD_DATA(LCD_DATA), .row_1(row_1), .row_2(row_2),
    .disp_on(disp_on), .two_line(two_line), .addr(addr),
    .busy(busy), .cmd_strobe(cmd_strobe),
    .data_strobe(data_strobe), .overrun(overrun)
  );

  always #10 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    bit is_data;
    int due;
  } sb_t;

  typedef struct {
    bit         rs;
    logic [7:0] v;
    bit         two;
    bit         disp;
    bit         ovr;
    logic [6:0] a;
  } vec_t;

  sb_t  sbq[$];
  sb_t  ent;
  vec_t tbl[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   last_stb = 0;

  always @(negedge CLK) begin
    if (_RST === 1'b1 && (cmd_strobe !== 1'b0 || data_strobe !== 1'b0)) begin
      n_chk++;
      if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL strobe_unexpected: cmd=%0b data=%0b cycle %0d, required no strobe",
                 cmd_strobe, data_strobe, cyc);
      end else begin
        ent = sbq.pop_front();
        if (cmd_strobe !== !ent.is_data || data_strobe !== ent.is_data
            || cyc != ent.due) begin
          n_fail++;
          $display("FAIL strobe_kind: cmd=%0b data=%0b cycle %0d, required data=%0b cycle %0d",
                   cmd_strobe, data_strobe, cyc, ent.is_data, ent.due);
        end
      end
      last_stb = cyc;
    end
  end

  task automatic chk(input string n, input logic [159:0] a,
                     input logic [159:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", n, a, e);
    end
  endtask

  task automatic chkv(input string n, input int a, input int e);
    n_chk++;
    if (a != e) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", n, a, a, e, e);
    end
  endtask

  task automatic send(input bit rs, input bit r, input logic [7:0] v);
    @(negedge CLK);
    LCD_RS   = rs;
    rw       = r;
    LCD_DATA = v;
    LCD_E    = 1'b1;
    repeat (3) @(negedge CLK);
    LCD_E = 1'b0;
    if (!r) sbq.push_back('{is_data: rs, due: cyc + 3});
    repeat (5) @(negedge CLK);
  endtask

  task automatic busy_len(input string n, input int e);
    int k;
    k = 0;
    while (busy === 1'b1 && k < 10000) begin
      @(negedge CLK);
      k++;
    end
    if (busy !== 1'b0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: busy=%b after %0d cycles, required 0", n, busy, k);
    end else begin
      chkv(n, cyc - last_stb, e);
    end
  endtask

  task automatic add(input bit rs, input logic [7:0] v, input bit two,
                     input bit disp, input bit ovr, input logic [6:0] a);
    tbl.push_back('{rs: rs, v: v, two: two, disp: disp, ovr: ovr, a: a});
  endtask

  logic [159:0] blank, hello, r2;

  initial begin
    blank = {20{8'h20}};
    hello = blank;
    hello[159:120] = 40'h48454C4C4F;

    add(0, 8'h38, 1, 0, 0, 7'h00);
    add(0, 8'h08, 1, 0, 1, 7'h00);
    add(0, 8'h01, 1, 0, 1, 7'h00);
    add(0, 8'h06, 1, 0, 1, 7'h00);
    add(0, 8'h0C, 1, 1, 1, 7'h00);
    add(0, 8'h80, 1, 1, 1, 7'h00);
    add(1, 8'h48, 1, 1, 1, 7'h01);
    add(1, 8'h45, 1, 1, 1, 7'h02);
    add(1, 8'h4C, 1, 1, 1, 7'h03);
    add(1, 8'h4C, 1, 1, 1, 7'h04);
    add(1, 8'h4F, 1, 1, 1, 7'h05);
    add(0, 8'hB0, 1, 1, 1, 7'h40);
    add(0, 8'hF0, 1, 1, 1, 7'h00);
    add(0, 8'hA7, 1, 1, 1, 7'h27);
    add(1, 8'h7E, 1, 1, 1, 7'h40);
    add(0, 8'hE7, 1, 1, 1, 7'h67);
    add(1, 8'h7E, 1, 1, 1, 7'h00);
    add(0, 8'h14, 1, 1, 1, 7'h01);
    add(0, 8'h10, 1, 1, 1, 7'h00);
    add(0, 8'h10, 1, 1, 1, 7'h67);
    add(0, 8'h18, 1, 1, 1, 7'h67);
    add(0, 8'h02, 1, 1, 1, 7'h00);
    add(0, 8'h40, 1, 1, 1, 7'h00);
    add(1, 8'h99, 1, 1, 1, 7'h00);
    add(0, 8'h80, 1, 1, 1, 7'h00);
    add(0, 8'h00, 1, 1, 1, 7'h00);
    add(0, 8'h30, 0, 1, 1, 7'h00);
    add(0, 8'h38, 1, 1, 1, 7'h00);

    repeat (3) @(negedge CLK);
    chk("rst_row_1", row_1, blank);
    chk("rst_row_2", row_2, blank);
    chkv("rst_disp_on", int'(disp_on), 0);
    chkv("rst_two_line", int'(two_line), 0);
    chkv("rst_addr", int'(addr), 0);
    chkv("rst_busy", int'(busy), 0);
    chkv("rst_overrun", int'(overrun), 0);
    chkv("rst_strobes", int'({cmd_strobe, data_strobe}), 0);
    _RST = 1'b1;
    repeat (2) @(negedge CLK);

    for (int i = 0; i < tbl.size(); i++) begin
      send(tbl[i].rs, 1'b0, tbl[i].v);
      chkv($sformatf("v%0d_two_line", i), int'(two_line), int'(tbl[i].two));
      chkv($sformatf("v%0d_disp_on", i), int'(disp_on), int'(tbl[i].disp));
      chkv($sformatf("v%0d_overrun", i), int'(overrun), int'(tbl[i].ovr));
      chkv($sformatf("v%0d_addr", i), int'(addr), int'(tbl[i].a));
    end
    chk("hello_row_1", row_1, hello);
    chk("hello_row_2", row_2, blank);

    send(0, 0, 8'hC0);
    r2 = blank;
    for (int i = 0; i < 20; i++) begin
      send(1, 0, 8'h41 + 8'(i));
      r2[159-8*i -: 8] = 8'h41 + 8'(i);
    end
    chkv("row2_fill_addr", int'(addr), 'h54);
    send(1, 0, 8'h5A);
    chkv("row2_over_addr", int'(addr), 'h55);
    chk("row2_fill_row_2", row_2, r2);
    chk("row2_fill_row_1", row_1, hello);

    send(0, 0, 8'h04);
    send(0, 0, 8'h80);
    send(1, 0, 8'h31);
    hello[159:152] = 8'h31;
    chk("dec_row_1", row_1, hello);
    chkv("dec_wrap_addr", int'(addr), 'h67);
    send(1, 0, 8'h32);
    chkv("dec_disc_addr", int'(addr), 'h66);
    chk("dec_disc_row_1", row_1, hello);
    chk("dec_disc_row_2", row_2, r2);
    send(0, 0, 8'hC0);
    send(1, 0, 8'h33);
    r2[159:152] = 8'h33;
    chkv("dec_40_addr", int'(addr), 'h27);
    chk("dec_40_row_2", row_2, r2);

    send(0, 1, 8'h01);
    send(1, 1, 8'h55);
    chkv("rw_addr", int'(addr), 'h27);
    chk("rw_row_1", row_1, hello);
    chk("rw_row_2", row_2, r2);

    send(0, 0, 8'h08);
    chkv("off_disp_on", int'(disp_on), 0);
`ifdef LCD_RX_BLANK_WHEN_OFF_EN
    chk("off_row_1", row_1, blank);
    chk("off_row_2", row_2, blank);
`else
    chk("off_row_1", row_1, hello);
    chk("off_row_2", row_2, r2);
`endif
    send(0, 0, 8'h0C);
    chk("on_row_1", row_1, hello);
    chk("on_row_2", row_2, r2);

    @(negedge CLK);
    chkv("pre_rst_busy", int'(busy), 1);
    _RST = 1'b0;
    #1;
    chkv("midrst_busy", int'(busy), 0);
    chkv("midrst_overrun", int'(overrun), 0);
    chkv("midrst_addr", int'(addr), 0);
    chk("midrst_row_1", row_1, blank);
    repeat (2) @(negedge CLK);
    _RST = 1'b1;
    repeat (2) @(negedge CLK);

    send(0, 0, 8'h01);
    busy_len("clear_busy_len", CLR);
    chkv("clear_overrun", int'(overrun), 0);

    send(0, 0, 8'h01);
    repeat (95) @(negedge CLK);
    send(1, 0, 8'h41);
    chkv("ovr_overrun", int'(overrun), 1);
    busy_len("data_busy_len", BUSY);
    r2 = blank;
    r2[159:152] = 8'h41;
    chk("ovr_row_1", row_1, r2);
    chkv("ovr_addr", int'(addr), 1);
    chkv("ovr_sticky", int'(overrun), 1);

    repeat (4) @(negedge CLK);
    chkv("sb_drained", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd2002_bus_receiver.md
Name: lcd2002_bus_receiver

Overview:
- Synthesizable receive-side model of the HD44780-style 20x2 LCD bus driven by the team's LCD2002 writer.
- Samples LCD_E/LCD_RS/rw/LCD_DATA, decodes instructions, and maintains a DDRAM image.
- Presents the visible 20x2 characters as two 160-bit row buses in the writer's packing.
- Used for in-FPGA loopback checks, on-board mirroring to other displays/UART, and as the bench scoreboard for the writer.

Parameters:
- BUSY_CYCLES, 2000, busy-window length after any accepted strobe except clear (40 us at 50 MHz).
- CLEAR_BUSY_CYCLES, 82000, busy-window length after a clear-display instruction (1.64 ms at 50 MHz).

Ports:
- CLK  input  1  system clock (50 MHz).
- _RST  input  1  reset; asynchronous, active-low.
- LCD_E  input  1  bus enable; a command executes on its falling edge.
- LCD_RS  input  1  0 = instruction, 1 = data.
- rw  input  1  0 = write; 1 = read cycle (ignored).
- LCD_DATA  input  8  bus data.
- row_1  output  160  visible row 1; column 0 = [159:152], column 19 = [7:0].
- row_2  output  160  visible row 2; same packing as row_1.
- disp_on  output  1  display-control D bit.
- two_line  output  1  function-set N bit.
- addr  output  7  current DDRAM address counter.
- busy  output  1  high during the busy window.
- cmd_strobe  output  1  one-cycle pulse per executed instruction.
- data_strobe  output  1  one-cycle pulse per executed data write, whether stored or discarded.
- overrun  output  1  sticky; set when a strobe arrives while busy.

Behaviour:
- Reset values:
  - DDRAM all 0x20, so every row byte is 0x20.
  - disp_on=0, two_line=0, addr=0x00, increment mode I/D=1.
  - busy=0, both strobes 0, overrun=0, CGRAM-mode flag 0.
  - Reset mid-operation aborts the busy window and restores all of the above.
- Input synchronisation:
  - LCD_E, LCD_RS, rw and LCD_DATA pass through an identical 2-flop synchroniser.
  - A third flop on E provides fall detection; fall = e_d3 & ~e_d2.
  - RS, rw and DATA are taken from the stage aligned with e_d2.
- Latency: all register effects and strobes appear on the clock edge after the fall is detected, i.e. the 3rd rising CLK edge after LCD_E is first sampled low.
- Strobe acceptance:
  - rw=1: the fall is ignored entirely (no strobe, no busy).
  - busy=1: the command is still executed, and overrun is set to 1.
  - Every executed strobe reloads the busy counter, so busy stays high for exactly N cycles, then goes low.
- Instructions (RS=0), priority by highest set bit:
  - 1xxxxxxx set DDRAM address; clears the CGRAM flag. Value 0x28..0x3F maps to 0x40; 0x68..0x7F maps to 0x00.
  - 01xxxxxx set CGRAM address; sets the CGRAM flag.
  - 001xxxxx function set; two_line = bit3.
  - 0001xxxx shift; bit3=0 moves the cursor by ±1 (bit2=1 right) using the wrap rules below; bit3=1 (display shift) is a no-op.
  - 00001xxx display control; disp_on = bit2.
  - 000001xx entry mode; I/D = bit1; S ignored.
  - 0000001x return home; addr=0.
  - 00000001 clear; DDRAM all 0x20 (single cycle), addr=0, I/D=1, busy window = CLEAR_BUSY_CYCLES.
  - 0x00 no-op, but still pulses cmd_strobe and starts the busy window.
- Data writes (RS=1):
  - CGRAM flag set: discarded; the address counter is unchanged.
  - Otherwise: store at addr if addr is in 0x00..0x13 (row 1, column = addr) or 0x40..0x53 (row 2, column = addr-0x40). Addresses 0x14..0x27 and 0x54..0x67 are discarded.
  - addr then steps by I/D.
- Address wrap:
  - Increment: 0x27→0x40, 0x67→0x00.
  - Decrement: 0x00→0x67, 0x40→0x27.
  - Wrap is the same regardless of two_line.
- Counters: busy counter is 17 bits, counting down to 0. CLEAR_BUSY_CYCLES must be ≤ 131071.

Optional Feature:
- Macro: LCD_RX_BLANK_WHEN_OFF_EN.
- Defined: row_1/row_2 are forced to all 0x20 while disp_on=0. DDRAM still updates, and its contents reappear when disp_on returns to 1.
- Undefined: rows always reflect DDRAM, independent of disp_on.

Test Plan:
- Reset, then drive the writer init sequence 38,08,01,06,0C → two_line=1, disp_on=1, addr=0, 5 cmd_strobes, row_1 = row_2 = 20×0x20.
- 0x80 then "HELLO" (48 45 4C 4C 4F) → row_1[159:120]=48454C4C4F, rest 0x20, addr=0x05.
- 0xC0 then 20 data bytes 0x41..0x54, then one more 0x5A → row_2 = 41..54, 0x5A discarded (addr 0x54), final addr=0x55.
- Entry 0x04, set address 0x80, write 0x31 → row_1 column0=0x31, addr=0x67; next write discarded, addr=0x66.
- Strobe 0x01 then a data strobe 100 cycles later with BUSY_CYCLES=2000 → overrun=1, data written at 0x00, busy high 2000 cycles after the second strobe.
- rw=1 falls on LCD_E → no strobe, no state change. With the macro defined and 0x08 sent → rows read all 0x20; 0x0C restores the prior text.
